vdp_vram_write_scheduler: RTL
=============================

// Module: vdp_vram_write_scheduler
// PURPOSE
//  Host-side VRAM write queue feeding the VDP bus arbiter's write slot. The arbiter grants one write
//  slot every 8 pixels. Accepts writes from two requesters, the CPU bus and the optional DMA copy
//  engine, arbitrates between them and buffers them in a FIFO. Presents the FIFO head on the
//  arbiter's write port. Retires an entry only when the slot actually committed it (not overridden by affine fetch).
// PARAMETERS
//  FIFO_DEPTH  8  entries; power of 2, >=2; level width LW = $clog2(FIFO_DEPTH)+1
// PORTS
//  clk                      in   1   pixel clock
//  reset_n                  in   1   async reset, active low
//  cpu_write_valid          in   1   CPU write request
//  cpu_write_ready          out  1   CPU write accepted this cycle when valid&ready
//  cpu_write_address        in   14  16-bit-word VRAM address
//  cpu_write_data           in   16  write data
//  cpu_write_mask           in   2   port enable {odd,even}
//  dma_write_valid          in   1   DMA write request
//  dma_write_ready          out  1   DMA write accepted this cycle when valid&ready
//  dma_write_address        in   14  DMA word address
//  dma_write_data           in   16  DMA write data
//  dma_write_mask           in   2   DMA port enable {odd,even}
//  vram_written             in   1   arbiter write-slot strobe (raster_x_offset[2:0]==0)
//  vram_write_blocked       in   1   affine owns bus this slot; the write was suppressed
//  vram_port_write_en_mask  out  2   to arbiter; 0 when FIFO empty
//  vram_write_address_16b   out  14  to arbiter; FIFO head address
//  vram_write_data_16b      out  16  to arbiter; FIFO head data
//  fifo_level               out  LW  occupied entries, 0..FIFO_DEPTH
//  idle                     out  1   FIFO empty and no request valid
// BEHAVIOUR
//  - Reset (async, reset_n=0): rd/wr pointers=0, fifo_level=0, mask=0, addr/data=0, both readys=0,
//    last_grant=DMA (CPU wins first tie). Entries in flight are discarded; no partial retirement.
//  - Entry = {mask[1:0], address[13:0], data[15:0]}; at most one push and one pop per cycle.
//  - Push arbitration (combinational from registered full + valids):
//    * full (level==FIFO_DEPTH): both readys 0.
//    * one valid: that requester ready=1. Both valid: grant != last_grant (alternate);
//      last_grant updates only on an accepted push.
//    * ready never depends on same-cycle pop: push refused while full even if a pop occurs.
//    * requester holds valid and payload stable until accepted; mask==0 entries are queued normally.
//  - Head presentation: registered; an entry pushed into an empty FIFO appears at the outputs on the
//    next cycle (accept->present latency 1). Outputs update one cycle after each pop.
//  - Pop: vram_written && !vram_write_blocked && level!=0. Blocked slot: entry retained, retried at
//    next slot (8 cycles later). vram_written with empty FIFO: no-op, no underflow, mask stays 0.
//  - Simultaneous push+pop: level unchanged; pointers both advance; wrap modulo FIFO_DEPTH.
//  - Outputs when empty: mask=0, address/data hold last value (arbiter ignores them with mask 0).
//  - idle = (level==0) && !cpu_write_valid && !dma_write_valid.
//  - State per requester is stateless apart from last_grant; no FSM beyond FIFO counters.
// CONFIGURATION
//  VDP_VRAM_WRITE_DMA_EN defined: DMA port is arbitrated as above.
//  Undefined: dma_write_ready tied 0, DMA inputs ignored, CPU granted whenever not full,
//    last_grant register removed.
// TESTING
//  1 CPU write addr=0x0123 data=0xBEEF mask=2'b11 into empty FIFO -> next cycle outputs
//    0x0123/0xBEEF/11, level=1; next vram_written -> level=0, mask=0 the following cycle.
//  2 8 CPU writes, no vram_written -> level=8, cpu_write_ready=0; one vram_written ->
//    level=7, ready=1 the cycle after; retirement order matches push order (FIFO).
//  3 Head queued, vram_written with vram_write_blocked=1 -> level unchanged, same head; next
//    unblocked slot pops it.
//  4 DMA_EN, cpu and dma valid continuously, slots every 8 cycles -> accepts alternate CPU,DMA,
//    CPU,...; first accept is CPU; without macro dma_write_ready never asserts.
//  5 Empty FIFO, vram_written pulses for 4 slots -> level stays 0, mask stays 0, no pointer movement.
//  6 level=5, reset_n low mid-cycle -> level=0, mask=0, readys=0 immediately (async); after
//    release, new write behaves as test 1.

Source files
------------

// File: rtl/vdp_vram_write_scheduler.sv
// Host-side VRAM write queue: arbitrates CPU/DMA writes into a FIFO and presents its head to the
// VDP arbiter write slot. Define VDP_VRAM_WRITE_DMA_EN to enable the DMA requester port.
module vdp_vram_write_scheduler #(
  parameter int FIFO_DEPTH = 8,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_write_valid,
  output logic          cpu_write_ready,
  input  logic [13:0]   cpu_write_address,
  input  logic [15:0]   cpu_write_data,
  input  logic [1:0]    cpu_write_mask,
  input  logic          dma_write_valid,
  output logic          dma_write_ready,
  input  logic [13:0]   dma_write_address,
  input  logic [15:0]   dma_write_data,
  input  logic [1:0]    dma_write_mask,
  input  logic          vram_written,
  input  logic          vram_write_blocked,
  output logic [1:0]    vram_port_write_en_mask,
  output logic [13:0]   vram_write_address_16b,
  output logic [15:0]   vram_write_data_16b,
  output logic [LW-1:0] fifo_level,
  output logic          idle
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic [1:0]    mask_q, mask_d;
  logic [13:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;

  logic        full, push, pop, cpuGrant, dmaGrant, anyValid;
  logic [31:0] pushEntry, headEntry;

  // Readiness comes from the registered level only, and is forced low while reset is held.
  assign full = (level_q == LW'(FIFO_DEPTH));

`ifdef VDP_VRAM_WRITE_DMA_EN
  logic lastGrant_q, lastGrant_d;

  always_comb begin
    cpuGrant = 1'b0;
    dmaGrant = 1'b0;
    if (reset_n && !full) begin
      if (cpu_write_valid && dma_write_valid) begin
        cpuGrant = lastGrant_q;
        dmaGrant = !lastGrant_q;
      end else begin
        cpuGrant = cpu_write_valid;
        dmaGrant = dma_write_valid;
      end
    end
  end

  always_comb begin
    lastGrant_d = lastGrant_q;
    if (dmaGrant) lastGrant_d = 1'b1;
    else if (cpuGrant) lastGrant_d = 1'b0;
  end

  // lastGrant_q = 1 means DMA won most recently, so the CPU wins the first tie after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lastGrant_q <= 1'b1;
    else          lastGrant_q <= lastGrant_d;
  end

  assign pushEntry = dmaGrant ? {dma_write_mask, dma_write_address, dma_write_data}
                              : {cpu_write_mask, cpu_write_address, cpu_write_data};
  assign anyValid  = cpu_write_valid || dma_write_valid;
`else
  logic dma_unused;

  assign dma_unused = ^{dma_write_valid, dma_write_address, dma_write_data, dma_write_mask};
  assign cpuGrant   = reset_n && !full && cpu_write_valid;
  assign dmaGrant   = 1'b0;
  assign pushEntry  = {cpu_write_mask, cpu_write_address, cpu_write_data};
  assign anyValid   = cpu_write_valid;
`endif

  assign push = cpuGrant || dmaGrant;
  assign pop  = vram_written && !vram_write_blocked && (level_q != '0);

  assign cpu_write_ready = cpuGrant;
  assign dma_write_ready = dmaGrant;

  always_comb begin
    rdPtr_d   = rdPtr_q + PW'(pop);
    wrPtr_d   = wrPtr_q + PW'(push);
    level_d   = level_q + LW'(push) - LW'(pop);
    headEntry = mem_q[rdPtr_d];
    mask_d    = mask_q;
    addr_d    = addr_q;
    data_d    = data_q;
    // The new head bypasses the array when it is the entry being written this cycle.
    if (push && (rdPtr_d == wrPtr_q)) headEntry = pushEntry;
    if (level_d == '0) begin
      mask_d = 2'b00;
    end else begin
      {mask_d, addr_d, data_d} = headEntry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      level_q <= '0;
      mask_q  <= 2'b00;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      level_q <= level_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= pushEntry;
  end

  assign vram_port_write_en_mask = mask_q;
  assign vram_write_address_16b  = addr_q;
  assign vram_write_data_16b     = data_q;
  assign fifo_level              = level_q;
  assign idle                    = (level_q == '0) && !anyValid;

endmodule
